// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding word reads to
// instruction memory, buffers returned words and presents {instr, PC+4} to decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0020,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             drop_q, drop_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_instr_q [DEPTH];
  logic [31:0]      buf_instr_d [DEPTH];
  logic [31:0]      buf_pc_q    [DEPTH];
  logic [31:0]      buf_pc_d    [DEPTH];
  logic             push;
  logic             pop;
  logic [31:0]      target_al;

  // Next-state: request sequencing, redirect handling and buffer bookkeeping
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_d      = drop_q;
    req_d       = req_q;
    addr_d      = addr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    push        = 1'b0;
    target_al   = br_target & ~32'h0000_0003;
    pop         = (count_q != '0) && instr_ready && !br_taken;

    case (state_q)
      S_FETCH: begin
        // A redirect this cycle would make fetch_pc stale, so hold off one cycle
        if (!br_taken) begin
          if (count_q < CNT_W'(DEPTH)) begin
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
            state_d = S_WAIT;
          end else begin
            state_d = S_STALL;
          end
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          drop_d  = 1'b0;
          state_d = S_FETCH;
          if (!drop_q && !br_taken) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (br_taken) begin
          drop_d = 1'b1;
        end
      end
      S_STALL: begin
        if (pop || br_taken) state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
      end
    endcase

    if (push) begin
      buf_instr_d[wr_ptr_q] = imem_rdata;
      buf_pc_d[wr_ptr_q]    = addr_q + 32'd4;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (br_taken) begin
      fetch_pc_d = target_al;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_q      <= drop_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = buf_instr_q[rd_ptr_q];
  assign pc_out      = buf_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, backpressure, redirects, PC wrap, async reset.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int total = 0;
  int bad   = 0;

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a request, check its address, answer it one cycle later
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    for (int i = 0; i < 8 && !imem_req; i++) step();
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    br_taken    = 1'b0;
    br_target   = '0;
    instr_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_addr",  imem_addr,        32'h0040_0020);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out,        32'h0);
    chk("rst_pc",    pc_out,           32'h0);

    // First fetch after reset
    reset = 1'b0;
    do_fetch("t1", 32'h0040_0020, 32'h2001_0005);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr_out,        32'h2001_0005);
    chk("t1_pc",    pc_out,           32'h0040_0024);

    // Backpressure: fill two slots, then stall
    do_reset();
    instr_ready = 1'b0;
    do_fetch("t2a", 32'h0040_0020, 32'h1111_0001);
    do_fetch("t2b", 32'h0040_0024, 32'h1111_0002);
    step();
    step();
    chk("t2_stall_req", 32'(imem_req), 32'd0);
    chk("t2_head_ins",  instr_out,     32'h1111_0001);
    chk("t2_head_pc",   pc_out,        32'h0040_0024);
    instr_ready = 1'b1;
    step();
    chk("t2_pop1_ins", instr_out, 32'h1111_0002);
    chk("t2_pop1_pc",  pc_out,    32'h0040_0028);
    step();
    chk("t2_empty",  32'(instr_valid), 32'd0);
    chk("t2_resume", 32'(imem_req),    32'd1);
    do_fetch("t2c", 32'h0040_0028, 32'h1111_0003);
    chk("t2c_pc", pc_out, 32'h0040_002C);

    // Redirect while a request is pending: stale response dropped
    step();
    chk("t3_wait_req", 32'(imem_req), 32'd1);
    br_taken  = 1'b1;
    br_target = 32'h0040_0100;
    step();
    br_taken  = 1'b0;
    chk("t3_addr_hold", imem_addr, 32'h0040_002C);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack   = 1'b0;
    chk("t3_stale_drop", 32'(instr_valid), 32'd0);
    do_fetch("t3", 32'h0040_0100, 32'h3333_0001);
    chk("t3_ins", instr_out, 32'h3333_0001);
    chk("t3_pc",  pc_out,    32'h0040_0104);

    // Redirect with same-cycle ack and pop, low target bits ignored
    instr_ready = 1'b0;
    step();
    chk("t4_req", 32'(imem_req), 32'd1);
    imem_ack    = 1'b1;
    imem_rdata  = 32'h4444_0001;
    instr_ready = 1'b1;
    br_taken    = 1'b1;
    br_target   = 32'h0040_0203;
    step();
    imem_ack  = 1'b0;
    br_taken  = 1'b0;
    chk("t4_flush", 32'(instr_valid), 32'd0);
    chk("t4_noreq", 32'(imem_req),    32'd0);
    do_fetch("t4", 32'h0040_0200, 32'h4444_0002);
    chk("t4_ins", instr_out, 32'h4444_0002);
    chk("t4_pc",  pc_out,    32'h0040_0204);

    // PC wrap at the top of the address space
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    step();
    br_taken  = 1'b0;
    chk("t5_flush", 32'(instr_valid), 32'd0);
    do_fetch("t5a", 32'hFFFF_FFFC, 32'h5555_0001);
    chk("t5a_pc", pc_out, 32'h0000_0000);
    do_fetch("t5b", 32'h0000_0000, 32'h5555_0002);
    chk("t5b_pc", pc_out, 32'h0000_0004);

    // Async reset mid-cycle during WAIT; later ack outside WAIT ignored
    instr_ready = 1'b0;
    step();
    chk("t6_pre_req",   32'(imem_req),    32'd1);
    chk("t6_pre_valid", 32'(instr_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_req",   32'(imem_req),    32'd0);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_addr",  imem_addr,        32'h0040_0020);
    #2;
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("t6_ack_ign", 32'(instr_valid), 32'd0);
    do_fetch("t6", 32'h0040_0020, 32'h6666_0001);
    chk("t6_ins", instr_out, 32'h6666_0001);
    chk("t6_pc",  pc_out,    32'h0040_0024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
